// File: rtl/mul_limb_sched_if.sv
// Request/response bundle for mul_limb_sched.
// The master side produces operands and consumes the product; the slave side
// is the multiplier controller.
interface mul_limb_sched_if #(
    parameter int WIDTH = 1024
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mul_limb_sched.sv
// mul_limb_sched: sequential WIDTH x WIDTH unsigned multiplier.
// It walks the K*K limb pairs (j inner, i outer), adding one LIMB x LIMB
// partial product per cycle into a 2*WIDTH accumulator that doubles as the
// product register.
// Optional build macro MUL_EARLY_ZERO_EN: a zero operand skips RUN and goes
// straight to DONE with a zero product.
module mul_limb_sched #(
    parameter int WIDTH = 1024,
    parameter int LIMB  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_limb_sched_if.slave  bus
);
    localparam int K  = WIDTH / LIMB;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [WIDTH-1:0]           r_opa;
    logic [WIDTH-1:0]           r_opb;
    logic [PW-1:0]              r_acc;
    logic [IW-1:0]              r_i;
    logic [IW-1:0]              r_j;

    logic [K-1:0][LIMB-1:0]     w_a_limbs;
    logic [K-1:0][LIMB-1:0]     w_b_limbs;
    logic [LIMB-1:0]            w_la;
    logic [LIMB-1:0]            w_lb;
    logic [2*LIMB-1:0]          w_pp;
    logic [IW:0]                w_ij;
    logic [31:0]                w_shamt;
    logic [PW-1:0]              w_pp_sh;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_zero;

    // Operand limbs selected by the current (i, j) pair.
    assign w_a_limbs = r_opa;
    assign w_b_limbs = r_opb;
    assign w_la      = w_a_limbs[r_i];
    assign w_lb      = w_b_limbs[r_j];
    assign w_pp      = {{LIMB{1'b0}}, w_la} * {{LIMB{1'b0}}, w_lb};

    // Partial product weight is 2^((i+j)*LIMB); i+j needs one extra bit.
    assign w_ij      = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt   = 32'(w_ij) * LIMB;
    assign w_pp_sh   = {{(PW-2*LIMB){1'b0}}, w_pp} << w_shamt;

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_last    = (r_i == LAST) && (r_j == LAST);

`ifdef MUL_EARLY_ZERO_EN
    assign w_zero    = (bus.a == '0) || (bus.b == '0);
`else
    assign w_zero    = 1'b0;
`endif

    assign bus.p     = r_acc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) w_next = w_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, limb index walk and accumulation. The accumulator is
    // only cleared on accept or reset, so p survives the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa <= '0;
            r_opb <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
        end else if (w_accept) begin
            r_opa <= bus.a;
            r_opb <= bus.b;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= r_acc + w_pp_sh;
            if (r_j == LAST) begin
                r_j <= '0;
                r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_limb_sched.sv
// Scoreboard bench for mul_limb_sched: the driver pushes the expected product
// and latency on every accept; the monitor pops and compares on each output
// handshake and checks output stability while the product is held.
module tb_mul_limb_sched;
    localparam int W  = 1024;
    localparam int L  = 64;
    localparam int K  = W / L;
    localparam int KK = K * K;

    typedef struct {
        logic [2*W-1:0] p;
        int             acc;
        int             lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vecs;
    int   errs;
    bit   rand_bp;
    exp_t sb[$];

    mul_limb_sched_if #(.WIDTH(W)) bus ();

    mul_limb_sched #(.WIDTH(W), .LIMB(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reference model: plain wide multiplication.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Edges from accept until out_valid is first seen.
    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_EARLY_ZERO_EN
        if (a == '0 || b == '0) return 0;
`endif
        return KK;
    endfunction

    function automatic logic [W-1:0] gen_op();
        logic [W/32-1:0][31:0] w;
        int m;
        m = int'($urandom_range(0, 3));
        w = '0;
        case (m)
            0: for (int i = 0; i < W/32; i++) w[i] = $urandom();
            1: w[$urandom_range(0, W/32-1)] = $urandom();
            2: w = '1;
            default: w[0] = $urandom_range(0, 15);
        endcase
        return w;
    endfunction

    task automatic chk_w(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", nm,
                     act[2*W-1 -: 64], act[127:0], exp[2*W-1 -: 64], exp[127:0]);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Present a request and hold it until accepted; records the expectation.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep, output int acc_cyc);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk_i("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        acc_cyc = cyc + 1;
        e.p   = ref_mul(a, b);
        e.acc = acc_cyc;
        e.lat = ref_lat(a, b);
        sb.push_back(e);
        if (!keep) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || bus.busy) chk_i("drain_timeout", 0, 1);
    endtask

    // Random backpressure during the random phase.
    always @(negedge clk) if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);

    // Monitor: latency on rise, product on handshake, stability while held.
    logic           prev_ov;
    logic           prev_hs;
    logic [2*W-1:0] prev_p;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov <= 1'b0;
            prev_hs <= 1'b0;
        end else begin
            chk_i("in_ready_vs_busy", int'(bus.in_ready), int'(!bus.busy));
            if (bus.out_valid && !prev_ov) begin
                if (sb.size() == 0) chk_i("unexpected_out_valid", 1, 0);
                else chk_i("latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (prev_ov && !prev_hs) begin
                chk_i("out_valid_hold", int'(bus.out_valid), 1);
                chk_w("p_hold", bus.p, prev_p);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) chk_i("unexpected_handshake", 1, 0);
                else begin
                    chk_w("product", bus.p, sb[0].p);
                    void'(sb.pop_front());
                end
            end
            prev_ov <= bus.out_valid;
            prev_hs <= bus.out_valid && bus.out_ready;
            prev_p  <= bus.p;
        end
    end

    initial begin
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] e;
        logic [2*W-1:0] t;
        int t1;
        int t2;
        int n;

        cyc = 0; vecs = 0; errs = 0; rand_bp = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_i("rst_in_ready", int'(bus.in_ready), 1);
        chk_i("rst_out_valid", int'(bus.out_valid), 0);
        chk_i("rst_busy", int'(bus.busy), 0);
        chk_w("rst_p", bus.p, '0);
        rst_n = 1'b1;

        // 1: small operands
        bus.out_ready = 1'b1;
        x = 1024'd3423; y = 1024'd434;
        send(x, y, 1'b0, t1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk_w("t1_p_after_hs", bus.p, 2048'd1485582);

        // 2: all ones, full carry ripple
        x = '1;
        send(x, x, 1'b0, t1);
        wait_idle();
        t = '0; t[1025] = 1'b1;
        e = '0; e = e - t + 2048'd1;
        chk_w("t2_allones", bus.p, e);

        // 3: backpressure with an ignored request pulse
        bus.out_ready = 1'b0;
        x = 1024'd123456789; y = 1024'd987654321;
        send(x, y, 1'b0, t1);
        n = 0;
        while (!bus.out_valid && n < 3000) begin @(negedge clk); n++; end
        chk_i("t3_reached_done", int'(bus.out_valid), 1);
        repeat (4) @(negedge clk);
        bus.a = 1024'd55; bus.b = 1024'd66; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk_i("t3_in_ready_held", int'(bus.in_ready), 0);
        repeat (5) @(negedge clk);
        chk_i("t3_out_valid_held", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        chk_i("t3_no_new_accept", int'(bus.busy), 0);
        chk_w("t3_p_kept", bus.p, ref_mul(1024'd123456789, 1024'd987654321));

        // 4: reset in the middle of RUN
        x = gen_op(); x[0] = 1'b1;
        send(x, x, 1'b0, t1);
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_i("t4_out_valid", int'(bus.out_valid), 0);
        chk_i("t4_in_ready", int'(bus.in_ready), 1);
        chk_i("t4_busy", int'(bus.busy), 0);
        chk_w("t4_p", bus.p, '0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1024'd7, 1024'd9, 1'b0, t1);
        wait_idle();
        chk_w("t4_p63", bus.p, 2048'd63);

        // 5: zero operand
        send('0, 1024'd5, 1'b0, t1);
        wait_idle();
        chk_w("t5_zero", bus.p, '0);

        // 6: back-to-back with in_valid and out_ready held high
        x = '0; x[W-1] = 1'b1;
        send(1024'd3, 1024'd5, 1'b1, t1);
        send(x, 1024'd2, 1'b0, t2);
        chk_i("t6_spacing", t2 - t1, KK + 2);
        wait_idle();
        e = '0; e[W] = 1'b1;
        chk_w("t6_last_p", bus.p, e);

        // Random operands with random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 12; k++) begin
            x = gen_op();
            y = gen_op();
            send(x, y, 1'b0, t1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        rand_bp = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;

        repeat (5) @(negedge clk);
        chk_i("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
